// File: rtl/instr_ram_loader.sv
// Boot loader: receives a length-prefixed little-endian image from a byte
// stream, writes it into instruction RAM and holds the CPU until it is complete.
module instr_ram_loader #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic                  busy,
    output logic                  done,
    output logic                  cpu_hold,
    output logic [1:0]            err,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned WL_W  = ADDR_WIDTH + 1;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_SIZE    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           n_words_q, n_words_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [CNT_W-1:0]      idle_q, idle_d;

    logic                  rx_ready_d;
    logic [DATA_WIDTH-1:0] ram_data_d;
    logic [ADDR_WIDTH-1:0] ram_addr_d;
    logic                  ram_we_d;
    logic                  busy_d;
    logic                  done_d;
    logic                  cpu_hold_d;
    logic [1:0]            err_d;
    logic [WL_W-1:0]       words_d;

    logic                  accept;
    logic                  timeout;
    logic [CNT_W-1:0]      idle_inc;
    logic [15:0]           hdr_n;
    logic [WL_W-1:0]       wl_inc;

    // State and registered outputs
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q      <= S_IDLE;
            n_words_q    <= '0;
            byte_idx_q   <= '0;
            idle_q       <= '0;
            rx_ready     <= 1'b0;
            ram_data     <= '0;
            ram_addr     <= '0;
            ram_we       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cpu_hold     <= 1'b1;
            err          <= ERR_NONE;
            words_loaded <= '0;
        end else begin
            state_q      <= state_d;
            n_words_q    <= n_words_d;
            byte_idx_q   <= byte_idx_d;
            idle_q       <= idle_d;
            rx_ready     <= rx_ready_d;
            ram_data     <= ram_data_d;
            ram_addr     <= ram_addr_d;
            ram_we       <= ram_we_d;
            busy         <= busy_d;
            done         <= done_d;
            cpu_hold     <= cpu_hold_d;
            err          <= err_d;
            words_loaded <= words_d;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they register in step
    always_comb begin
        state_d    = state_q;
        n_words_d  = n_words_q;
        byte_idx_d = byte_idx_q;
        idle_d     = idle_q;
        ram_data_d = ram_data;
        ram_addr_d = ram_addr;
        err_d      = err;
        words_d    = words_loaded;

        accept   = rx_valid && rx_ready;
        idle_inc = idle_q + CNT_W'(1);
        timeout  = !accept && (32'(idle_inc) >= TIMEOUT_CYCLES);
        hdr_n    = {rx_data, n_words_q[7:0]};
        wl_inc   = words_loaded + WL_W'(1);

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_HDR0;
                    idle_d  = '0;
                    err_d   = ERR_NONE;
                    words_d = '0;
                end
            end
            S_HDR0: begin
                if (accept) begin
                    n_words_d[7:0] = rx_data;
                    idle_d         = '0;
                    state_d        = S_HDR1;
                end else if (timeout) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = S_ERR;
                end else begin
                    idle_d = idle_inc;
                end
            end
            S_HDR1: begin
                if (accept) begin
                    n_words_d = hdr_n;
                    idle_d    = '0;
                    if (hdr_n == 16'd0) begin
                        state_d = S_DONE;
                    end else if (32'(hdr_n) > DEPTH) begin
                        err_d   = ERR_SIZE;
                        state_d = S_ERR;
                    end else begin
                        byte_idx_d = '0;
                        ram_addr_d = '0;
                        state_d    = S_DATA;
                    end
                end else if (timeout) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = S_ERR;
                end else begin
                    idle_d = idle_inc;
                end
            end
            S_DATA: begin
                if (accept) begin
                    // Shift in from the top so the first byte lands in bits [7:0]
                    ram_data_d = {rx_data, ram_data[DATA_WIDTH-1:8]};
                    byte_idx_d = byte_idx_q + 2'd1;
                    idle_d     = '0;
                    if (byte_idx_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end else if (timeout) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = S_ERR;
                end else begin
                    idle_d = idle_inc;
                end
            end
            S_WRITE: begin
                words_d = wl_inc;
                if (32'(wl_inc) == 32'(n_words_q)) begin
                    state_d = S_DONE;
                end else begin
                    ram_addr_d = ram_addr + ADDR_WIDTH'(1);
                    state_d    = S_DATA;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rx_ready_d = (state_d == S_HDR0) || (state_d == S_HDR1) || (state_d == S_DATA);
        ram_we_d   = (state_d == S_WRITE);
        busy_d     = rx_ready_d || ram_we_d;
        done_d     = (state_d == S_DONE);
        cpu_hold_d = (state_d != S_DONE);
    end

endmodule

// File: tb/tb_instr_ram_loader.sv
// Directed bench for instr_ram_loader with a behavioural RAM on the write port.
module tb_instr_ram_loader;

    localparam int unsigned AW = 10;
    localparam int unsigned TO = 16;

    logic          CLK = 1'b0;
    logic          RST_n;
    logic          start;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [31:0]   ram_data;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic          busy;
    logic          done;
    logic          cpu_hold;
    logic [1:0]    err;
    logic [AW:0]   words_loaded;

    instr_ram_loader #(
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK         (CLK),
        .RST_n       (RST_n),
        .start       (start),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .ram_data    (ram_data),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .busy        (busy),
        .done        (done),
        .cpu_hold    (cpu_hold),
        .err         (err),
        .words_loaded(words_loaded)
    );

    always #5 CLK = ~CLK;

    // RAM captures on the negedge; also log every write and handshake anomalies
    logic [31:0]   mem [0:1023];
    logic [AW-1:0] wr_addr [0:63];
    logic [31:0]   wr_data [0:63];
    int            wr_n      = 0;
    int            rdy_in_wr = 0;
    int            long_we   = 0;
    logic          prev_we   = 1'b0;

    always @(negedge CLK) begin
        prev_we <= ram_we;
        if (ram_we) begin
            mem[ram_addr]     <= ram_data;
            wr_addr[wr_n % 64] <= ram_addr;
            wr_data[wr_n % 64] <= ram_data;
            wr_n              <= wr_n + 1;
            if (rx_ready) rdy_in_wr <= rdy_in_wr + 1;
            if (prev_we)  long_we   <= long_we + 1;
        end
    end

    int total = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Hold the byte until it transfers; leaves rx_valid high for back-to-back use
    task automatic send_byte(input logic [7:0] b);
        int n;
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 40) begin
            tick();
            n++;
        end
        if (!rx_ready) chk("rx_ready_wait", 64'(rx_ready), 64'd1);
        else tick();
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    task automatic send_hdr(input logic [15:0] n);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int n;
        n = 0;
        while (!done && n < maxc) begin
            tick();
            n++;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
        chk({tag, "_ram_we"},   64'(ram_we),   64'd0);
        chk({tag, "_ram_data"}, 64'(ram_data), 64'd0);
        chk({tag, "_ram_addr"}, 64'(ram_addr), 64'd0);
        chk({tag, "_busy"},     64'(busy),     64'd0);
        chk({tag, "_done"},     64'(done),     64'd0);
        chk({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd1);
        chk({tag, "_err"},      64'(err),      64'd0);
        chk({tag, "_words"},    64'(words_loaded), 64'd0);
    endtask

    initial begin
        int base;
        int bad;
        RST_n    = 1'b0;
        start    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tick();
        tick();
        chk_reset_vals("reset");
        RST_n = 1'b1;
        tick();

        // Two-word image with latency and readback checks
        base = wr_n;
        do_start();
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_rx_ready", 64'(rx_ready), 64'd1);
        send_hdr(16'd2);
        send_word(32'h12345678);
        rx_valid = 1'b0;
        chk("t1_we_at_k", 64'(ram_we), 64'd1);
        chk("t1_addr_at_k", 64'(ram_addr), 64'd0);
        chk("t1_data_at_k", 64'(ram_data), 64'h12345678);
        chk("t1_ready_in_write", 64'(rx_ready), 64'd0);
        tick();
        chk("t1_we_after", 64'(ram_we), 64'd0);
        chk("t1_words_after", 64'(words_loaded), 64'd1);
        chk("t1_ready_after", 64'(rx_ready), 64'd1);
        send_word(32'hDEADBEEF);
        rx_valid = 1'b0;
        wait_done(10);
        chk("t1_writes", 64'(wr_n - base), 64'd2);
        chk("t1_w0_addr", 64'(wr_addr[base % 64]), 64'd0);
        chk("t1_w0_data", 64'(wr_data[base % 64]), 64'h12345678);
        chk("t1_w1_addr", 64'(wr_addr[(base + 1) % 64]), 64'd1);
        chk("t1_w1_data", 64'(wr_data[(base + 1) % 64]), 64'hDEADBEEF);
        chk("t1_mem1", 64'(mem[1]), 64'hDEADBEEF);
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_cpu_hold", 64'(cpu_hold), 64'd0);
        chk("t1_busy_end", 64'(busy), 64'd0);
        chk("t1_words", 64'(words_loaded), 64'd2);
        chk("t1_long_we", 64'(long_we), 64'd0);
        // Extra bytes after DONE are refused
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        tick();
        tick();
        tick();
        chk("t1_done_no_ready", 64'(rx_ready), 64'd0);
        chk("t1_done_no_write", 64'(wr_n - base), 64'd2);
        rx_valid = 1'b0;

        // Empty image
        base = wr_n;
        do_start();
        chk("t2_done_cleared", 64'(done), 64'd0);
        chk("t2_words_cleared", 64'(words_loaded), 64'd0);
        send_hdr(16'd0);
        rx_valid = 1'b0;
        tick();
        chk("t2_done", 64'(done), 64'd1);
        chk("t2_err", 64'(err), 64'd0);
        chk("t2_no_write", 64'(wr_n - base), 64'd0);

        // Oversized image, then recovery
        base = wr_n;
        do_start();
        send_hdr(16'h0401);
        rx_valid = 1'b0;
        tick();
        chk("t3_err", 64'(err), 64'd1);
        chk("t3_cpu_hold", 64'(cpu_hold), 64'd1);
        chk("t3_done", 64'(done), 64'd0);
        chk("t3_busy", 64'(busy), 64'd0);
        chk("t3_ready", 64'(rx_ready), 64'd0);
        chk("t3_no_write", 64'(wr_n - base), 64'd0);
        do_start();
        chk("t3_err_cleared", 64'(err), 64'd0);
        send_hdr(16'd1);
        send_word(32'h44332211);
        rx_valid = 1'b0;
        wait_done(10);
        chk("t3_rec_done", 64'(done), 64'd1);
        chk("t3_rec_err", 64'(err), 64'd0);
        chk("t3_rec_hold", 64'(cpu_hold), 64'd0);
        chk("t3_rec_data", 64'(wr_data[base % 64]), 64'h44332211);

        // Byte timeout during DATA
        base = wr_n;
        do_start();
        send_hdr(16'd2);
        send_byte(8'h01);
        send_byte(8'h02);
        rx_valid = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("t4_err_before", 64'(err), 64'd0);
        chk("t4_busy_before", 64'(busy), 64'd1);
        tick();
        chk("t4_err", 64'(err), 64'd2);
        chk("t4_ready", 64'(rx_ready), 64'd0);
        chk("t4_busy", 64'(busy), 64'd0);
        chk("t4_hold", 64'(cpu_hold), 64'd1);
        chk("t4_no_write", 64'(wr_n - base), 64'd0);

        // Back-to-back stream, rx_valid never drops
        base = wr_n;
        do_start();
        send_hdr(16'd4);
        send_word(32'hA1A2A3A4);
        send_word(32'hB1B2B3B4);
        send_word(32'hC1C2C3C4);
        send_word(32'hD1D2D3D4);
        rx_valid = 1'b0;
        wait_done(10);
        chk("t5_done", 64'(done), 64'd1);
        chk("t5_writes", 64'(wr_n - base), 64'd4);
        chk("t5_ready_in_write", 64'(rdy_in_wr), 64'd0);
        chk("t5_mem0", 64'(mem[0]), 64'hA1A2A3A4);
        chk("t5_mem1", 64'(mem[1]), 64'hB1B2B3B4);
        chk("t5_mem2", 64'(mem[2]), 64'hC1C2C3C4);
        chk("t5_mem3", 64'(mem[3]), 64'hD1D2D3D4);
        chk("t5_addr3", 64'(wr_addr[(base + 3) % 64]), 64'd3);

        // Async reset mid-load
        do_start();
        send_hdr(16'd3);
        send_word(32'h04030201);
        send_byte(8'h05);
        send_byte(8'h06);
        rx_valid = 1'b0;
        #3;
        RST_n = 1'b0;
        #1;
        chk_reset_vals("amid");
        #2;
        RST_n = 1'b1;
        tick();

        // Start pulses mid-load (HDR1, DATA, WRITE) are ignored
        base = wr_n;
        do_start();
        send_byte(8'h03);
        rx_valid = 1'b0;
        do_start();
        send_byte(8'h00);
        send_word(32'h11111111);
        rx_valid = 1'b0;
        chk("t6_in_write", 64'(ram_we), 64'd1);
        do_start();
        do_start();
        chk("t6_busy", 64'(busy), 64'd1);
        send_word(32'h22222222);
        send_word(32'h33333333);
        rx_valid = 1'b0;
        wait_done(10);
        chk("t6_done", 64'(done), 64'd1);
        chk("t6_writes", 64'(wr_n - base), 64'd3);
        chk("t6_w0", {32'(wr_addr[base % 64]), wr_data[base % 64]}, {32'd0, 32'h11111111});
        chk("t6_w1", {32'(wr_addr[(base + 1) % 64]), wr_data[(base + 1) % 64]}, {32'd1, 32'h22222222});
        chk("t6_w2", {32'(wr_addr[(base + 2) % 64]), wr_data[(base + 2) % 64]}, {32'd2, 32'h33333333});

        // Full-depth image: N = 1024 is legal and the address ends at 1023
        do_start();
        send_hdr(16'h0400);
        for (int i = 0; i < 1024; i++) send_word(32'hC0DE0000 | 32'(i));
        rx_valid = 1'b0;
        wait_done(10);
        chk("t7_done", 64'(done), 64'd1);
        chk("t7_err", 64'(err), 64'd0);
        chk("t7_words", 64'(words_loaded), 64'h400);
        chk("t7_last_addr", 64'(ram_addr), 64'h3FF);
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            if (mem[i] !== (32'hC0DE0000 | 32'(i))) bad++;
        end
        chk("t7_scan", 64'(bad), 64'd0);
        chk("t7_ready_in_write", 64'(rdy_in_wr), 64'd0);
        chk("t7_long_we", 64'(long_we), 64'd0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
